mips_cpu_ifetch: RTL and testbench

MIPS_CPU_IFETCH -- requirements
Module: mips_cpu_ifetch

---
 rtl/mips_cpu_pkg.sv | 17 +
 rtl/mips_cpu_ifetch.sv | 142 ++++++++++++++
 tb/tb_mips_cpu_ifetch.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS CPU instruction-fetch unit: reset defaults and FSM state type.
package mips_cpu_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;
    localparam logic [31:0] NOP_WORD_DEFAULT     = 32'h00000000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mips_cpu_ifetch.sv
// Instruction fetch: issues one Avalon-MM read per fetch request and holds the word until decode accepts it.
// Optional IFETCH_ALIGN_CHECK_EN: misaligned PCs skip the bus and return NOP_WORD with misalign raised.
module mips_cpu_ifetch
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [31:0] NOP_WORD     = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        fetch_req,
    input  logic        flush,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic [3:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] fetch_pc,
    output logic [31:0] pc_plus4,
    output logic        busy,
    output logic        misalign
);

    fetch_state_t r_state;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_instr;
    logic         r_instr_valid;
    logic         r_mem_read;
    logic         r_misalign;
    logic         r_discard;
    logic         w_start_misaligned;
    logic         w_handshake;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign w_start_misaligned = is_misaligned(pc_in);
    assign mem_address        = r_fetch_pc;
`else
    assign w_start_misaligned = 1'b0;
    assign mem_address        = {r_fetch_pc[31:2], 2'b00};
`endif

    assign w_handshake = r_instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_fetch_pc    <= RESET_VECTOR;
            r_instr       <= NOP_WORD;
            r_instr_valid <= 1'b0;
            r_mem_read    <= 1'b0;
            r_misalign    <= 1'b0;
            r_discard     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (flush) begin
                        r_instr       <= NOP_WORD;
                        r_instr_valid <= 1'b0;
                        r_misalign    <= 1'b0;
                    end else if (fetch_req) begin
                        r_fetch_pc <= pc_in;
                        if (w_start_misaligned) begin
                            r_state       <= ST_HOLD;
                            r_instr       <= NOP_WORD;
                            r_instr_valid <= 1'b1;
                            r_misalign    <= 1'b1;
                        end else begin
                            r_state    <= ST_REQ;
                            r_mem_read <= 1'b1;
                        end
                    end
                end

                // An Avalon read cannot be withdrawn, so a flush only marks the data for discard.
                ST_REQ: begin
                    if (flush) begin
                        r_discard <= 1'b1;
                    end
                    if (!mem_waitrequest) begin
                        r_mem_read <= 1'b0;
                        r_discard  <= 1'b0;
                        if (r_discard || flush) begin
                            r_state       <= ST_IDLE;
                            r_instr       <= NOP_WORD;
                            r_instr_valid <= 1'b0;
                        end else begin
                            r_state       <= ST_HOLD;
                            r_instr       <= mem_readdata;
                            r_instr_valid <= 1'b1;
                        end
                    end
                end

                ST_HOLD: begin
                    if (flush) begin
                        r_state       <= ST_IDLE;
                        r_instr       <= NOP_WORD;
                        r_instr_valid <= 1'b0;
                        r_misalign    <= 1'b0;
                    end else if (w_handshake) begin
                        r_instr_valid <= 1'b0;
                        r_misalign    <= 1'b0;
                        if (fetch_req) begin
                            r_fetch_pc <= pc_in;
                            if (w_start_misaligned) begin
                                r_state       <= ST_HOLD;
                                r_instr       <= NOP_WORD;
                                r_instr_valid <= 1'b1;
                                r_misalign    <= 1'b1;
                            end else begin
                                r_state    <= ST_REQ;
                                r_mem_read <= 1'b1;
                            end
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    r_state    <= ST_IDLE;
                    r_mem_read <= 1'b0;
                    r_discard  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_read       = r_mem_read;
    assign mem_byteenable = 4'b1111;
    assign instr          = r_instr;
    assign instr_valid    = r_instr_valid;
    assign fetch_pc       = r_fetch_pc;
    assign pc_plus4       = r_fetch_pc + 32'd4;
    assign busy           = (r_state != ST_IDLE);
    assign misalign       = r_misalign;

endmodule

// File: tb/tb_mips_cpu_ifetch.sv
// Directed self-checking bench for mips_cpu_ifetch; inputs change and outputs are sampled 1ns after posedge.
module tb_mips_cpu_ifetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        fetch_req;
    logic        flush;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [3:0]  mem_byteenable;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] fetch_pc;
    logic [31:0] pc_plus4;
    logic        busy;
    logic        misalign;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_cpu_ifetch dut (
        .clk             (clk),
        .reset           (reset),
        .pc_in           (pc_in),
        .fetch_req       (fetch_req),
        .flush           (flush),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_byteenable  (mem_byteenable),
        .mem_waitrequest (mem_waitrequest),
        .mem_readdata    (mem_readdata),
        .instr           (instr),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .fetch_pc        (fetch_pc),
        .pc_plus4        (pc_plus4),
        .busy            (busy),
        .misalign        (misalign)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; pc_in = '0; fetch_req = 1'b0; flush = 1'b0;
        mem_waitrequest = 1'b0; mem_readdata = '0; instr_ready = 1'b0;
        tick(); tick();
        chk("rst_fetch_pc", fetch_pc, 32'hBFC00000);
        chk("rst_pc_plus4", pc_plus4, 32'hBFC00004);
        chk("rst_instr", instr, 32'h00000000);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("byteenable", {28'd0, mem_byteenable}, 32'hF);
        reset = 1'b0;
        tick();

        // Zero-wait fetch
        $display("txn: fetch pc=bfc00000 zero-wait");
        pc_in = 32'hBFC00000; fetch_req = 1'b1; mem_readdata = 32'h24020005;
        tick();
        fetch_req = 1'b0;
        chk("t1_mem_read_n1", {31'd0, mem_read}, 32'd1);
        chk("t1_addr_n1", mem_address, 32'hBFC00000);
        chk("t1_valid_n1", {31'd0, instr_valid}, 32'd0);
        chk("t1_busy_n1", {31'd0, busy}, 32'd1);
        tick();
        chk("t1_valid_n2", {31'd0, instr_valid}, 32'd1);
        chk("t1_instr_n2", instr, 32'h24020005);
        chk("t1_pc_plus4", pc_plus4, 32'hBFC00004);
        chk("t1_mem_read_n2", {31'd0, mem_read}, 32'd0);

        // Decode stalls four cycles in HOLD
        $display("txn: hold with instr_ready low 4 cycles");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_valid", {31'd0, instr_valid}, 32'd1);
            chk("hold_instr", instr, 32'h24020005);
        end

        // Back-to-back fetch with three wait cycles
        $display("txn: back-to-back fetch pc=bfc00004 with 3 waits");
        instr_ready = 1'b1; fetch_req = 1'b1; pc_in = 32'hBFC00004;
        mem_waitrequest = 1'b1; mem_readdata = 32'h8C430000;
        tick();
        instr_ready = 1'b0; fetch_req = 1'b0;
        chk("b2b_mem_read_n1", {31'd0, mem_read}, 32'd1);
        chk("b2b_addr_n1", mem_address, 32'hBFC00004);
        chk("b2b_valid_n1", {31'd0, instr_valid}, 32'd0);
        chk("b2b_busy_n1", {31'd0, busy}, 32'd1);
        tick();
        chk("b2b_mem_read_n2", {31'd0, mem_read}, 32'd1);
        chk("b2b_addr_n2", mem_address, 32'hBFC00004);
        chk("b2b_valid_n2", {31'd0, instr_valid}, 32'd0);
        fetch_req = 1'b1; pc_in = 32'h12345678;
        tick();
        fetch_req = 1'b0;
        chk("b2b_ignore_req", fetch_pc, 32'hBFC00004);
        chk("b2b_mem_read_n3", {31'd0, mem_read}, 32'd1);
        tick();
        chk("b2b_mem_read_n4", {31'd0, mem_read}, 32'd1);
        chk("b2b_addr_n4", mem_address, 32'hBFC00004);
        chk("b2b_valid_n4", {31'd0, instr_valid}, 32'd0);
        mem_waitrequest = 1'b0;
        tick();
        chk("b2b_valid_n5", {31'd0, instr_valid}, 32'd1);
        chk("b2b_instr_n5", instr, 32'h8C430000);
        chk("b2b_mem_read_n5", {31'd0, mem_read}, 32'd0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("hs_valid_drop", {31'd0, instr_valid}, 32'd0);
        chk("hs_idle", {31'd0, busy}, 32'd0);

        // Flush during a waited read
        $display("txn: flush during waited read pc=00400000");
        pc_in = 32'h00400000; fetch_req = 1'b1; mem_waitrequest = 1'b1;
        tick();
        fetch_req = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_mem_read_a", {31'd0, mem_read}, 32'd1);
        chk("fl_addr_a", mem_address, 32'h00400000);
        tick();
        chk("fl_mem_read_b", {31'd0, mem_read}, 32'd1);
        mem_waitrequest = 1'b0; mem_readdata = 32'hDEADBEEF;
        tick();
        chk("fl_mem_read_done", {31'd0, mem_read}, 32'd0);
        chk("fl_valid", {31'd0, instr_valid}, 32'd0);
        chk("fl_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("fl_valid_later", {31'd0, instr_valid}, 32'd0);

        // Flush in HOLD beats a simultaneous fetch_req
        $display("txn: flush in hold with fetch_req pc=00400010");
        pc_in = 32'h00400010; fetch_req = 1'b1; mem_readdata = 32'h03E00008;
        tick();
        fetch_req = 1'b0;
        tick();
        chk("fh_valid", {31'd0, instr_valid}, 32'd1);
        chk("fh_instr", instr, 32'h03E00008);
        flush = 1'b1; fetch_req = 1'b1; pc_in = 32'h00400020;
        tick();
        flush = 1'b0; fetch_req = 1'b0;
        chk("fh_valid_clr", {31'd0, instr_valid}, 32'd0);
        chk("fh_instr_nop", instr, 32'h00000000);
        chk("fh_idle", {31'd0, busy}, 32'd0);
        chk("fh_mem_read", {31'd0, mem_read}, 32'd0);
        tick();
        chk("fh_still_idle", {31'd0, busy}, 32'd0);
        chk("fh_fetch_pc", fetch_pc, 32'h00400010);

        // PC wrap
        $display("txn: fetch pc=fffffffc wrap");
        pc_in = 32'hFFFFFFFC; fetch_req = 1'b1; mem_readdata = 32'h00000001;
        tick();
        fetch_req = 1'b0;
        chk("wrap_fetch_pc", fetch_pc, 32'hFFFFFFFC);
        chk("wrap_pc_plus4", pc_plus4, 32'h00000000);
        tick();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("wrap_idle", {31'd0, busy}, 32'd0);

        // Misaligned PC
        $display("txn: fetch misaligned pc=bfc00002");
        pc_in = 32'hBFC00002; fetch_req = 1'b1; mem_readdata = 32'h11111111;
        tick();
        fetch_req = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        chk("mis_mem_read", {31'd0, mem_read}, 32'd0);
        chk("mis_flag", {31'd0, misalign}, 32'd1);
        chk("mis_valid", {31'd0, instr_valid}, 32'd1);
        chk("mis_instr", instr, 32'h00000000);
        chk("mis_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("mis_mem_read_2", {31'd0, mem_read}, 32'd0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("mis_clear", {31'd0, misalign}, 32'd0);
`else
        chk("mis_mem_read", {31'd0, mem_read}, 32'd1);
        chk("mis_addr", mem_address, 32'hBFC00000);
        chk("mis_flag", {31'd0, misalign}, 32'd0);
        tick();
        chk("mis_valid", {31'd0, instr_valid}, 32'd1);
        chk("mis_instr", instr, 32'h11111111);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
`endif
        chk("mis_idle", {31'd0, busy}, 32'd0);

        // Reset in the middle of a waited read
        $display("txn: reset during waited read pc=00400040");
        pc_in = 32'h00400040; fetch_req = 1'b1; mem_waitrequest = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("rr_mem_read", {31'd0, mem_read}, 32'd1);
        reset = 1'b1; flush = 1'b1; fetch_req = 1'b1;
        tick();
        reset = 1'b0; flush = 1'b0; fetch_req = 1'b0; mem_waitrequest = 1'b0;
        chk("rr_mem_read_drop", {31'd0, mem_read}, 32'd0);
        chk("rr_busy", {31'd0, busy}, 32'd0);
        chk("rr_fetch_pc", fetch_pc, 32'hBFC00000);
        chk("rr_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("rr_valid_later", {31'd0, instr_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
